// File: rtl/spi_ram_responder_if.sv
// SPI mode-0 bus between the CPU (master) and the RAM responder (slave).
interface spi_ram_responder_if;
    logic spi_cs_n;
    logic spi_sck;
    logic spi_mosi;
    logic spi_miso;

    modport master (
        output spi_cs_n,
        output spi_sck,
        output spi_mosi,
        input  spi_miso
    );

    modport slave (
        input  spi_cs_n,
        input  spi_sck,
        input  spi_mosi,
        output spi_miso
    );
endinterface

// File: rtl/spi_ram_responder.sv
// SPI mode-0 SRAM responder, all SPI inputs oversampled in the clk domain.
// Optional RDSR/WRSR mode register enabled by defining SPI_RAM_STATUS_EN.
module spi_ram_responder #(
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    spi_ram_responder_if.slave  spi,
    output logic                busy,
    output logic                byte_wr,
    output logic                cmd_err
);

    typedef enum logic [2:0] {StIdle, StCmd, StAddr, StRd, StWr, StIgnore} state_e;

    logic [SYNC_STAGES-1:0] cs_sync, sck_sync, mosi_sync;
    logic                   cs_prev_q, sck_prev_q;
    logic                   cs_s, sck_s, mosi_s;
    logic                   cs_fall, cs_rise, sck_rise, sck_fall;

    state_e            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        shift_in_q, shift_in_d;
    logic [7:0]        shift_out_q, shift_out_d;
    logic [ADDR_W-1:0] addr_q, addr_d, addr_in, addr_nxt;
    logic              miso_q, miso_d;
    logic              rd_q, rd_d;
    logic              mem_we;
    logic [7:0]        byte_full;
    logic              last_bit;
    logic              inc;
    logic [7:0]        mem [2**ADDR_W];

`ifdef SPI_RAM_STATUS_EN
    logic [7:0] mode_q, mode_d;
    logic       sr_q, sr_d;
    assign inc = mode_q[6];
`else
    assign inc = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync    <= '1;
            sck_sync   <= '0;
            mosi_sync  <= '0;
            cs_prev_q  <= 1'b1;
            sck_prev_q <= 1'b0;
        end else begin
            cs_sync    <= {cs_sync[SYNC_STAGES-2:0], spi.spi_cs_n};
            sck_sync   <= {sck_sync[SYNC_STAGES-2:0], spi.spi_sck};
            mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], spi.spi_mosi};
            cs_prev_q  <= cs_s;
            sck_prev_q <= sck_s;
        end
    end

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sck_s     = sck_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cs_fall   = cs_prev_q & ~cs_s;
    assign cs_rise   = ~cs_prev_q & cs_s;
    assign sck_rise  = sck_s & ~sck_prev_q;
    assign sck_fall  = ~sck_s & sck_prev_q;
    assign byte_full = {shift_in_q, mosi_s};
    assign last_bit  = sck_rise && (bit_cnt_q == 3'd7);
    // Only the low ADDR_W bits of the address byte select a location.
    assign addr_in   = byte_full[ADDR_W-1:0];
    assign addr_nxt  = addr_q + ADDR_W'(inc);
    assign busy      = (state_q != StIdle);
    assign spi.spi_miso = miso_q;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_in_d  = shift_in_q;
        shift_out_d = shift_out_q;
        addr_d      = addr_q;
        miso_d      = miso_q;
        rd_d        = rd_q;
        mem_we      = 1'b0;
        byte_wr     = 1'b0;
        cmd_err     = 1'b0;
`ifdef SPI_RAM_STATUS_EN
        mode_d      = mode_q;
        sr_d        = sr_q;
`endif
        if (sck_rise && state_q != StIdle) begin
            shift_in_d = byte_full[6:0];
            bit_cnt_d  = bit_cnt_q + 3'd1;
        end

        unique case (state_q)
            StIdle: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    state_d   = StCmd;
                    bit_cnt_d = 3'd0;
                    rd_d      = 1'b0;
`ifdef SPI_RAM_STATUS_EN
                    sr_d      = 1'b0;
`endif
                end
            end
            StCmd: begin
                if (last_bit) begin
                    unique case (byte_full)
                        8'h03: begin state_d = StAddr; rd_d = 1'b1; end
                        8'h02: begin state_d = StAddr; rd_d = 1'b0; end
`ifdef SPI_RAM_STATUS_EN
                        8'h05: begin state_d = StRd; sr_d = 1'b1; shift_out_d = mode_q; end
                        8'h01: begin state_d = StWr; sr_d = 1'b1; end
`endif
                        default: begin state_d = StIgnore; cmd_err = 1'b1; end
                    endcase
                end
            end
            StAddr: begin
                if (last_bit) begin
                    addr_d = addr_in;
                    if (rd_q) begin
                        shift_out_d = mem[addr_in];
                        state_d     = StRd;
                    end else begin
                        state_d = StWr;
                    end
                end
            end
            StRd: begin
                // Falls present the next bit; the 8th rise reloads for the next byte.
                if (sck_fall) begin
                    miso_d      = shift_out_q[7];
                    shift_out_d = {shift_out_q[6:0], 1'b0};
                end
                if (last_bit) begin
`ifdef SPI_RAM_STATUS_EN
                    if (sr_q) begin
                        shift_out_d = mode_q;
                    end else begin
                        addr_d      = addr_nxt;
                        shift_out_d = mem[addr_nxt];
                    end
`else
                    addr_d      = addr_nxt;
                    shift_out_d = mem[addr_nxt];
`endif
                end
            end
            StWr: begin
                if (last_bit) begin
`ifdef SPI_RAM_STATUS_EN
                    if (sr_q) begin
                        mode_d  = byte_full;
                        state_d = StIgnore;
                    end else begin
                        mem_we  = 1'b1;
                        byte_wr = 1'b1;
                        addr_d  = addr_nxt;
                    end
`else
                    mem_we  = 1'b1;
                    byte_wr = 1'b1;
                    addr_d  = addr_nxt;
`endif
                end
            end
            StIgnore: miso_d = 1'b0;
            default:  state_d = StIdle;
        endcase

        // CS release wins over any SCK edge detected in the same clk.
        if (cs_rise) begin
            state_d   = StIdle;
            miso_d    = 1'b0;
            bit_cnt_d = 3'd0;
            mem_we    = 1'b0;
            byte_wr   = 1'b0;
            cmd_err   = 1'b0;
`ifdef SPI_RAM_STATUS_EN
            mode_d    = mode_q;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shift_in_q  <= '0;
            shift_out_q <= '0;
            addr_q      <= '0;
            miso_q      <= 1'b0;
            rd_q        <= 1'b0;
`ifdef SPI_RAM_STATUS_EN
            mode_q      <= 8'h40;
            sr_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_in_q  <= shift_in_d;
            shift_out_q <= shift_out_d;
            addr_q      <= addr_d;
            miso_q      <= miso_d;
            rd_q        <= rd_d;
`ifdef SPI_RAM_STATUS_EN
            mode_q      <= mode_d;
            sr_q        <= sr_d;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '{default: '0};
        end else if (mem_we) begin
            mem[addr_q] <= byte_full;
        end
    end

endmodule

// File: tb/tb_spi_ram_responder.sv
// Directed bench for spi_ram_responder; define SPI_RAM_STATUS_EN to cover RDSR/WRSR.
module tb_spi_ram_responder;
    logic clk;
    logic rst_n;
    logic busy, byte_wr, cmd_err;
    int   total, bad;
    int   wr_cnt, err_cnt;
    logic [7:0] rx;

    spi_ram_responder_if bus ();

    spi_ram_responder #(
        .ADDR_W      (5),
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .spi     (bus),
        .busy    (busy),
        .byte_wr (byte_wr),
        .cmd_err (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (byte_wr) wr_cnt++;
        if (cmd_err) err_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Master side: drive mosi while SCK low, sample miso just before each rise.
    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] r);
        r = '0;
        for (int i = 0; i < n; i++) begin
            bus.spi_mosi = tx[7-i];
            clks(5);
            r[7-i] = bus.spi_miso;
            bus.spi_sck = 1'b1;
            clks(5);
            bus.spi_sck = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] r);
        spi_bits(tx, 8, r);
    endtask

    task automatic cs_lo();
        @(negedge clk);
        bus.spi_cs_n = 1'b0;
        clks(5);
    endtask

    task automatic cs_hi();
        clks(5);
        bus.spi_cs_n = 1'b1;
        clks(8);
    endtask

    initial begin
        total = 0; bad = 0; wr_cnt = 0; err_cnt = 0;
        rst_n = 1'b0;
        bus.spi_cs_n = 1'b1;
        bus.spi_sck  = 1'b0;
        bus.spi_mosi = 1'b0;
        clks(4);
        check("rst_busy", busy, 0);
        check("rst_miso", bus.spi_miso, 0);
        check("rst_byte_wr", byte_wr, 0);
        check("rst_cmd_err", cmd_err, 0);
        rst_n = 1'b1;
        clks(4);

        // Single-byte read of cleared memory.
        cs_lo();
        xfer(8'h03, rx);
        check("busy_in_frame", busy, 1);
        xfer(8'h04, rx);
        xfer(8'h00, rx);
        check("rd_04", rx, 8'h00);
        clks(5);
        bus.spi_cs_n = 1'b1;
        clks(3);
        check("busy_drop_3clk", busy, 0);
        clks(5);

        // Write across the top of memory, then read back with wrap.
        wr_cnt = 0;
        cs_lo();
        xfer(8'h02, rx); xfer(8'h1E, rx);
        xfer(8'hA5, rx); xfer(8'h5A, rx); xfer(8'hC3, rx);
        cs_hi();
        check("wr3_pulses", wr_cnt, 3);
        check("wr3_miso_idle", bus.spi_miso, 0);
        cs_lo();
        xfer(8'h03, rx); xfer(8'h1E, rx);
        xfer(8'h00, rx); check("rd_1e", rx, 8'hA5);
        xfer(8'h00, rx); check("rd_1f", rx, 8'h5A);
        xfer(8'h00, rx); check("rd_00_wrap", rx, 8'hC3);
        cs_hi();

        // Upper address bits are ignored.
        cs_lo();
        xfer(8'h02, rx); xfer(8'hE7, rx); xfer(8'h11, rx);
        cs_hi();
        cs_lo();
        xfer(8'h03, rx); xfer(8'h07, rx); xfer(8'h00, rx);
        cs_hi();
        check("rd_07_alias", rx, 8'h11);

        // Unsupported command.
        err_cnt = 0;
        wr_cnt  = 0;
        cs_lo();
        xfer(8'h9F, rx);
        check("bad_cmd_err", err_cnt, 1);
        xfer(8'hFF, rx); check("ign_miso0", rx, 8'h00);
        xfer(8'h02, rx); check("ign_miso1", rx, 8'h00);
        cs_hi();
        check("bad_cmd_err_once", err_cnt, 1);
        check("bad_cmd_no_wr", wr_cnt, 0);
        cs_lo();
        xfer(8'h03, rx); xfer(8'h00, rx); xfer(8'h00, rx);
        cs_hi();
        check("rd_after_err", rx, 8'hC3);

        // Partial write byte is discarded.
        wr_cnt = 0;
        cs_lo();
        xfer(8'h02, rx); xfer(8'h02, rx);
        spi_bits(8'hFF, 5, rx);
        cs_hi();
        check("partial_no_wr", wr_cnt, 0);
        cs_lo();
        xfer(8'h03, rx); xfer(8'h02, rx); xfer(8'h00, rx);
        cs_hi();
        check("partial_mem_kept", rx, 8'h00);

`ifdef SPI_RAM_STATUS_EN
        cs_lo();
        xfer(8'h05, rx);
        xfer(8'h00, rx); check("rdsr_0", rx, 8'h40);
        xfer(8'h00, rx); check("rdsr_1", rx, 8'h40);
        cs_hi();
        cs_lo();
        xfer(8'h01, rx); xfer(8'h00, rx);
        cs_hi();
        wr_cnt = 0;
        cs_lo();
        xfer(8'h02, rx); xfer(8'h03, rx); xfer(8'h12, rx); xfer(8'h34, rx);
        cs_hi();
        check("bytemode_wr", wr_cnt, 2);
        cs_lo();
        xfer(8'h03, rx); xfer(8'h03, rx);
        xfer(8'h00, rx); check("bytemode_rd0", rx, 8'h34);
        xfer(8'h00, rx); check("bytemode_rd1", rx, 8'h34);
        cs_hi();
`else
        err_cnt = 0;
        cs_lo();
        xfer(8'h05, rx);
        cs_hi();
        cs_lo();
        xfer(8'h01, rx);
        cs_hi();
        check("status_cmds_err", err_cnt, 2);
`endif

        // Async reset in the middle of a read clears everything.
        cs_lo();
        xfer(8'h03, rx); xfer(8'h1E, rx);
        spi_bits(8'h00, 4, rx);
        rst_n = 1'b0;
        #1;
        check("midrd_rst_miso", bus.spi_miso, 0);
        check("midrd_rst_busy", busy, 0);
        bus.spi_cs_n = 1'b1;
        clks(3);
        rst_n = 1'b1;
        clks(4);
        cs_lo();
        xfer(8'h03, rx); xfer(8'h1E, rx);
        xfer(8'h00, rx); check("rst_mem_1e", rx, 8'h00);
        cs_hi();
        cs_lo();
        xfer(8'h03, rx); xfer(8'h07, rx);
        xfer(8'h00, rx); check("rst_mem_07", rx, 8'h00);
        cs_hi();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_ram_responder.md
Name: spi_ram_responder

Overview:
- Synthesizable SPI mode-0 SRAM responder; the memory-side end of the CPU's SPI bus.
- Answers the CPU's READ/WRITE byte transactions over spi_cs_n/spi_sck/spi_mosi/spi_miso.
- Used as an on-die RAM model for test mode and for cocotb/board bring-up without an external PMOD RAM.
- All SPI inputs are oversampled in the clk domain; nothing is clocked by SCK.

Parameters:
- ADDR_W, 5, memory address width; depth = 2**ADDR_W bytes.
- SYNC_STAGES, 2, synchronizer flops on cs_n/sck/mosi (minimum 2).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- spi_cs_n  input  1  chip select, active low
- spi_sck  input  1  SPI clock, idle low (mode 0)
- spi_mosi  input  1  data from CPU, MSB first
- spi_miso  output  1  data to CPU, MSB first
- busy  output  1  high while a synchronized CS is asserted
- byte_wr  output  1  one-clk pulse when a data byte is committed to memory
- cmd_err  output  1  one-clk pulse when an unsupported command byte completes

Behaviour:
- Reset: async on rst_n low.
  - Clears spi_miso, busy, byte_wr, cmd_err, the shift register, bit counter, address and every memory byte (all to 0).
  - Sets the FSM to IDLE.
- Sync and edge detect:
  - cs_n, sck and mosi each pass through SYNC_STAGES flops.
  - rise/fall are detected from the synchronized sck and its previous value.
  - Constraint on the master: SCK high time and low time are each at least 4 clk.
- Sampling: mosi is sampled on a detected SCK rise; miso changes only on a detected SCK fall or on a state entry.
  - Required miso valid time: at most SYNC_STAGES+1 clk after the SCK fall.
- Frame format: command byte, then address byte (low ADDR_W bits used, upper bits ignored), then N data bytes.
- Commands: 0x03 READ, 0x02 WRITE.
- FSM states: IDLE, CMD, ADDR, RD, WR, IGNORE.
- IDLE:
  - spi_miso = 0.
  - On synchronized cs_n fall: go to CMD, clear bit counter, set busy = 1.
- CMD: after 8 rises,
  - 0x03 -> ADDR with rd flag set.
  - 0x02 -> ADDR with wr flag set.
  - Any other value -> IGNORE, plus a cmd_err pulse in the same clk.
- ADDR:
  - After 8 rises, latch addr.
  - Read: load shift_out = mem[addr] and go to RD. Bit 7 is presented on the next SCK fall.
  - Write: go to WR.
- RD:
  - Each fall shifts the next bit onto miso.
  - After the 8th rise of a byte: addr = addr+1 mod 2**ADDR_W, reload shift_out = mem[addr].
  - Bit 7 of the new byte appears on the following fall.
  - Reading past the top wraps to address 0.
- WR:
  - After the 8th rise: mem[addr] = shifted byte, pulse byte_wr, addr = addr+1 mod 2**ADDR_W.
  - The write lands in the same clk as the rise is detected.
- IGNORE: miso held 0 until CS deasserts.
- CS deassert (synchronized rising edge) in any state: return to IDLE on that clk.
  - busy = 0 and spi_miso = 0.
  - A partial write byte is discarded; memory is unchanged.
  - Bit counter cleared.
- CS deasserted and reasserted: always starts a fresh command; no state carries between frames except memory.
- Simultaneous CS rise and SCK rise in the same clk: the CS rise wins and the SCK edge is dropped.
- SCK edges while CS is high are ignored.
- No data latency inside memory: read data for byte k+1 is available one SCK period after byte k ends, with no dummy cycles.

Optional Feature:
- Macro: SPI_RAM_STATUS_EN.
- When defined, adds command 0x05 RDSR and command 0x01 WRSR, backed by an 8-bit mode register (reset 0x40).
  - RDSR: returns mode_reg repeatedly on miso for as long as CS stays asserted.
  - WRSR: takes the next 8 bits into mode_reg; further bytes are ignored.
  - mode_reg bit 6 = 1 enables sequential auto-increment.
  - mode_reg bit 6 = 0 (byte mode): RD/WR do not increment addr, so repeated bytes hit the same address.
- When not defined:
  - 0x05 and 0x01 are unsupported and produce cmd_err.
  - Auto-increment is always on.

Test Plan:
- Reset, then READ 0x03, addr 0x04, 1 byte -> miso returns 0x00; busy high during the frame and low within 3 clk of the CS rise.
- WRITE 0x02, addr 0x1E, data 0xA5 0x5A 0xC3 -> three byte_wr pulses; memory holds 0x1E=0xA5, 0x1F=0x5A, 0x00=0xC3 (wrap). Then READ addr 0x1E, 3 bytes -> 0xA5 0x5A 0xC3.
- Address 0xE7 sent with ADDR_W=5 -> accesses 0x07. Write 0x11 there, read back 0x11 via address 0x07.
- Command 0x9F -> one cmd_err pulse; miso stays 0 for 16 further SCKs; the next frame READ 0x00 works normally.
- WRITE addr 0x02 with byte 0xFF, CS deasserted after 5 bits -> no byte_wr; a read of 0x02 returns its prior value. Separately, assert rst_n low mid-READ -> miso = 0, busy = 0 immediately, memory cleared.
- With SPI_RAM_STATUS_EN:
  - RDSR -> 0x40.
  - WRSR 0x00, then WRITE addr 0x03 with 0x12 0x34, then READ addr 0x03 -> 0x34 (byte mode, no increment).
